// File: rtl/axis_pack32_if.sv
// Pixel-in / packed-word-out stream pair of the output packer.
// master: the side that feeds pixels and consumes words; slave: the packer itself.
interface axis_pack32_if;
    // Pixel stream from the filter (no tready: every valid beat is taken)
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tkeep;
    logic        s_axis_tlast;
    // Packed word stream to the DMA
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tkeep, s_axis_tlast, m_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/axis_pack32.sv
// Packs 8-bit grey pixels four per 32-bit AXI-Stream word, buffering whole lines in a FIFO.
// Lines that do not fit at their first pixel are dropped whole; SOF goes on tuser.
module axis_pack32 #(
    parameter int unsigned LINE_PIX    = 640,
    parameter int unsigned FRAME_LINES = 512,
    parameter int unsigned FIFO_ASIZE  = 9
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    axis_pack32_if.slave  axis,
    output logic          ovf_o,
    output logic          len_err_o,
    output logic [15:0]   drop_cnt_o,
    input  logic          err_clr_i
);

    localparam int unsigned WORDS  = LINE_PIX / 4;
    localparam int unsigned DEPTH  = 2 ** FIFO_ASIZE;
    localparam int unsigned CW     = FIFO_ASIZE + 2;
    localparam int unsigned PIX_W  = $clog2(LINE_PIX + 1);
    localparam int unsigned LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(LINE_PIX);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    typedef enum logic [1:0] {StSol, StLine, StDrop} state_e;

    // Word layout in the FIFO: {tuser, tlast, tkeep[3:0], tdata[31:0]}
    state_e              state_q, state_d;
    logic [31:0]         pack_q, pack_d;
    logic [1:0]          lanes_q, lanes_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                wr_valid_q, form;
    logic [37:0]         wr_word_q, wr_word_d, fifo_wd;
    logic [LINE_W-1:0]   line_q;
    logic                sof_pend_q, ovf_q, len_err_q;
    logic [15:0]         drop_q;
    logic [37:0]         mem_q [DEPTH];
    logic [FIFO_ASIZE-1:0] wptr_q, rptr_q;
    logic [FIFO_ASIZE:0] count_q;
    logic                out_valid_q, out_valid_d;
    logic [37:0]         out_word_q, out_word_d;

    logic acc, eol, free_ok, trunc, late_last, len_evt, drop_evt, push, pop;
    logic [PIX_W-1:0] pix_inc;
    logic [CW-1:0]    used_w;

    assign acc     = axis.s_axis_tvalid & axis.s_axis_tkeep;
    assign eol     = axis.s_axis_tvalid & axis.s_axis_tlast;
    assign pix_inc = pix_q + PIX_W'(1);
    // Room for a whole line, counting the word still waiting in the write stage
    assign used_w  = {1'b0, count_q} + CW'(wr_valid_q) + CW'(WORDS);
    assign free_ok = (used_w <= CW'(DEPTH));
    // Line reached its nominal length without tlast: close it here
    assign trunc   = (state_q == StLine) & acc & ~eol & (pix_inc == PIX_FULL);
    assign drop_evt = (state_q == StSol) & acc & ~free_ok;

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= StSol;
        else         state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSol:   if (acc && !eol) state_d = free_ok ? StLine : StDrop;
            StLine:  if (eol) state_d = StSol;
                     else if (trunc) state_d = StDrop;
            StDrop:  if (eol) state_d = StSol;
            default: state_d = StSol;
        endcase
    end

    // FSM outputs: byte packing, word formation and error events
    always_comb begin
        logic             in_line, keep_pix, word_last;
        logic [1:0]       lanes_cur;
        logic [PIX_W-1:0] pix_cur, pix_new;
        logic [31:0]      pack_cur, pack_new, word_data;
        logic [3:0]       word_keep;
        in_line   = (state_q == StLine);
        lanes_cur = in_line ? lanes_q : 2'd0;
        pix_cur   = in_line ? pix_q : '0;
        pack_cur  = in_line ? pack_q : 32'd0;
        keep_pix  = acc & (in_line | ((state_q == StSol) & free_ok));
        pix_new   = pix_cur + PIX_W'(1);
        pack_new  = pack_cur | (32'(axis.s_axis_tdata) << {lanes_cur, 3'b000});
        lanes_d   = lanes_cur;
        pix_d     = pix_cur;
        pack_d    = pack_cur;
        form      = 1'b0;
        word_data = 32'd0;
        word_keep = 4'd0;
        word_last = 1'b0;
        late_last = 1'b0;
        len_evt   = 1'b0;
        if (keep_pix) begin
            pix_d   = pix_new;
            len_evt = (eol & (pix_new != PIX_FULL)) | trunc;
            if (lanes_cur == 2'd3 || eol || trunc) begin
                form      = 1'b1;
                word_data = pack_new;
                word_keep = 4'hF >> (2'd3 - lanes_cur);
                word_last = eol | trunc;
                pack_d    = 32'd0;
                lanes_d   = 2'd0;
            end else begin
                pack_d  = pack_new;
                lanes_d = lanes_cur + 2'd1;
            end
        end else if (in_line && eol) begin
            // tlast on an empty beat: flush the partial word, or tag the word just completed
            len_evt = (pix_cur != PIX_FULL);
            if (lanes_cur != 2'd0) begin
                form      = 1'b1;
                word_data = pack_cur;
                word_keep = 4'hF >> (2'd3 - (lanes_cur - 2'd1));
                word_last = 1'b1;
                pack_d    = 32'd0;
                lanes_d   = 2'd0;
            end else if (wr_valid_q) begin
                late_last = 1'b1;
            end else begin
                form      = 1'b1;
                word_last = 1'b1;
            end
        end
        wr_word_d = {sof_pend_q, word_last, word_keep, word_data};
    end

    // Packing state, write stage, frame tracking and sticky errors
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pack_q     <= 32'd0;
            lanes_q    <= 2'd0;
            pix_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_word_q  <= 38'd0;
            line_q     <= '0;
            sof_pend_q <= 1'b1;
            ovf_q      <= 1'b0;
            len_err_q  <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            pack_q     <= pack_d;
            lanes_q    <= lanes_d;
            pix_q      <= pix_d;
            wr_valid_q <= form;
            wr_word_q  <= wr_word_d;
            if (eol) line_q <= (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
            // A frame wrap re-arms SOF even if a word is formed in the same cycle
            if (eol && line_q == LINE_LAST) sof_pend_q <= 1'b1;
            else if (form)                  sof_pend_q <= 1'b0;
            if (drop_evt)       ovf_q <= 1'b1;
            else if (err_clr_i) ovf_q <= 1'b0;
            if (len_evt)        len_err_q <= 1'b1;
            else if (err_clr_i) len_err_q <= 1'b0;
            if (drop_evt)       drop_q <= err_clr_i ? 16'd1
                                        : (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            else if (err_clr_i) drop_q <= 16'd0;
        end
    end

    // FIFO pop / bypass into the registered output word
    always_comb begin
        fifo_wd     = wr_word_q | {1'b0, late_last, 36'd0};
        pop         = 1'b0;
        push        = 1'b0;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q & ~axis.m_axis_tready;
        if (!out_valid_q || axis.m_axis_tready) begin
            if (count_q != '0) begin
                pop         = 1'b1;
                out_valid_d = 1'b1;
                out_word_d  = mem_q[rptr_q];
            end else if (wr_valid_q) begin
                out_valid_d = 1'b1;
                out_word_d  = fifo_wd;
            end
        end
        push = wr_valid_q & ~(out_valid_d & ~pop & (count_q == '0) & ~out_valid_q)
             & ~(wr_valid_q & (count_q == '0) & (!out_valid_q || axis.m_axis_tready));
        push = push & ((count_q != (FIFO_ASIZE+1)'(DEPTH)) | pop);
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= fifo_wd;
    end

    // FIFO pointers and output register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= 38'd0;
        end else begin
            if (push) wptr_q <= wptr_q + FIFO_ASIZE'(1);
            if (pop)  rptr_q <= rptr_q + FIFO_ASIZE'(1);
            count_q     <= count_q + (FIFO_ASIZE+1)'(push) - (FIFO_ASIZE+1)'(pop);
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign axis.m_axis_tvalid = out_valid_q;
    assign axis.m_axis_tdata  = out_word_q[31:0];
    assign axis.m_axis_tkeep  = out_word_q[35:32];
    assign axis.m_axis_tlast  = out_word_q[36];
    assign axis.m_axis_tuser  = out_word_q[37];
    assign ovf_o      = ovf_q;
    assign len_err_o  = len_err_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_axis_pack32.sv
// Directed bench for axis_pack32: packing, SOF, truncation, drop on FIFO full, reset.
module tb_axis_pack32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, err_clr;
    logic        ovf, len_err, s_ovf, s_len_err;
    logic [15:0] drop_cnt, s_drop_cnt;

    axis_pack32_if bus ();
    axis_pack32_if sbus ();

    axis_pack32 dut (
        .clk_i(clk), .rstn_i(rstn), .axis(bus), .ovf_o(ovf), .len_err_o(len_err),
        .drop_cnt_o(drop_cnt), .err_clr_i(err_clr)
    );

    // Short lines and frames so a frame wrap fits in a small run
    axis_pack32 #(.LINE_PIX(8), .FRAME_LINES(4), .FIFO_ASIZE(3)) dut_s (
        .clk_i(clk), .rstn_i(rstn), .axis(sbus), .ovf_o(s_ovf), .len_err_o(s_len_err),
        .drop_cnt_o(s_drop_cnt), .err_clr_i(1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {tuser, tlast, tkeep, tdata} of word i of a line with pixel = index mod 256
    function automatic logic [37:0] exp_word(input int i, input logic user, input logic last);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * i);
        b1 = 8'(4 * i + 1);
        b2 = 8'(4 * i + 2);
        b3 = 8'(4 * i + 3);
        return {user, last, 4'hF, b3, b2, b1, b0};
    endfunction

    logic [37:0] mq[$];
    logic [37:0] sq[$];
    logic [37:0] mon_w, held_w;
    logic        held_v = 1'b0;

    // Collect handshaken words; a stalled word must stay put until taken
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = 1'b0;
        end else begin
            mon_w = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
            if (held_v) check("hold", {bus.m_axis_tvalid, mon_w}, {1'b1, held_w});
            if (bus.m_axis_tvalid && bus.m_axis_tready) mq.push_back(mon_w);
            held_v = bus.m_axis_tvalid && !bus.m_axis_tready;
            held_w = mon_w;
        end
    end

    always @(negedge clk) begin
        if (rstn && sbus.m_axis_tvalid && sbus.m_axis_tready)
            sq.push_back({sbus.m_axis_tuser, sbus.m_axis_tlast, sbus.m_axis_tkeep,
                          sbus.m_axis_tdata});
    end

    task automatic px(input logic [7:0] d, input logic keep, input logic last);
        @(posedge clk); #1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tkeep  = keep;
        bus.s_axis_tlast  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tkeep  = 1'b0;
            bus.s_axis_tlast  = 1'b0;
            bus.s_axis_tdata  = 8'd0;
        end
    endtask

    // n pixels, tlast on the last; optional empty (tkeep=0) beat after each pixel
    task automatic send_line(input int n, input logic gaps);
        for (int i = 0; i < n; i++) begin
            px(8'(i), 1'b1, i == n - 1);
            if (gaps && i < n - 1) px(8'hEE, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && mq.size() < n; k++) @(negedge clk);
        repeat (8) @(negedge clk);
        check("word_count", mq.size(), n);
    endtask

    task automatic spx(input logic [7:0] d, input logic last);
        @(posedge clk); #1;
        sbus.s_axis_tdata  = d;
        sbus.s_axis_tvalid = 1'b1;
        sbus.s_axis_tkeep  = 1'b1;
        sbus.s_axis_tlast  = last;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b1;
        err_clr = 1'b0;
        bus.s_axis_tdata = 8'd0; bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tkeep = 1'b0; bus.s_axis_tlast = 1'b0; bus.m_axis_tready = 1'b1;
        sbus.s_axis_tdata = 8'd0; sbus.s_axis_tvalid = 1'b0;
        sbus.s_axis_tkeep = 1'b0; sbus.s_axis_tlast = 1'b0; sbus.m_axis_tready = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, 32'd0);
        check("rst_tuser", bus.m_axis_tuser, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        rstn = 1'b1;

        // Frame wrap on the small instance: 5 lines of 8 px, 4 lines per frame
        for (int l = 0; l < 5; l++)
            for (int k = 0; k < 8; k++) spx(8'(16 * l + k), k == 7);
        @(posedge clk); #1;
        sbus.s_axis_tvalid = 1'b0; sbus.s_axis_tlast = 1'b0;
        repeat (20) @(negedge clk);
        check("frame_count", sq.size(), 10);
        for (int j = 0; j < 10 && j < sq.size(); j++) begin
            logic [7:0] b;
            b = 8'(16 * (j / 2) + 4 * (j % 2));
            check("frame_word", sq[j], {(j == 0 || j == 8) ? 1'b1 : 1'b0, (j % 2) == 1,
                  4'hF, 8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b});
        end

        // Full-size line with first-word latency probe
        for (int i = 0; i < 640; i++) begin
            px(8'(i), 1'b1, i == 639);
            if (i == 4) begin @(negedge clk); check("lat_1cyc", bus.m_axis_tvalid, 1'b0); end
            if (i == 5) begin @(negedge clk); check("lat_2cyc", bus.m_axis_tvalid, 1'b1); end
        end
        idle(1);
        wait_words(160, 400);
        for (int i = 0; i < 160 && i < mq.size(); i++)
            check("line_word", mq[i], exp_word(i, i == 0, i == 159));
        check("line_len_err", len_err, 1'b0);
        check("line_ovf", ovf, 1'b0);
        mq.delete();

        // Overlong line: closed at 640 px, remainder discarded until tlast
        send_line(644, 1'b0);
        idle(1);
        wait_words(160, 400);
        for (int i = 0; i < 160 && i < mq.size(); i++)
            check("long_word", mq[i], exp_word(i, 1'b0, i == 159));
        check("long_len_err", len_err, 1'b1);
        mq.delete();

        // Short 6-pixel line: partial last word
        for (int i = 0; i < 6; i++) px(8'(8'h10 + i), 1'b1, i == 5);
        idle(1);
        wait_words(2, 50);
        if (mq.size() == 2) begin
            check("short_w0", mq[0], {2'b00, 4'hF, 32'h13121110});
            check("short_w1", mq[1], {2'b01, 4'b0011, 32'h00001514});
        end
        mq.delete();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("clr_len_err", len_err, 1'b0);

        // Empty beats interleaved: same words, no errors
        send_line(640, 1'b1);
        idle(1);
        wait_words(160, 400);
        for (int i = 0; i < 160 && i < mq.size(); i++)
            check("gap_word", mq[i], exp_word(i, 1'b0, i == 159));
        check("gap_len_err", len_err, 1'b0);
        mq.delete();

        // Stalled DMA: three lines fit, the fourth is dropped
        @(posedge clk); #1 bus.m_axis_tready = 1'b0;
        for (int l = 0; l < 4; l++) send_line(640, 1'b0);
        idle(5);
        @(negedge clk);
        check("stall_ovf", ovf, 1'b1);
        check("stall_drop_cnt", drop_cnt, 16'd1);
        check("stall_tvalid", bus.m_axis_tvalid, 1'b1);
        check("stall_len_err", len_err, 1'b0);
        @(posedge clk); #1 bus.m_axis_tready = 1'b1;
        wait_words(480, 1200);
        for (int i = 0; i < 480 && i < mq.size(); i++)
            check("drain_word", mq[i], exp_word(i % 160, 1'b0, (i % 160) == 159));
        mq.delete();

        // Reset mid-line with a word held and 2 pixels packed
        @(posedge clk); #1 bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) px(8'(8'h30 + i), 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("pre_rst_tvalid", bus.m_axis_tvalid, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("mid_rst_tdata", bus.m_axis_tdata, 32'd0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_drop_cnt", drop_cnt, 16'd0);
        @(negedge clk);
        rstn = 1'b1;
        bus.m_axis_tready = 1'b1;
        px(8'hAA, 1'b1, 1'b0);
        px(8'hBB, 1'b1, 1'b0);
        px(8'hCC, 1'b1, 1'b0);
        px(8'hDD, 1'b1, 1'b1);
        idle(1);
        wait_words(1, 50);
        if (mq.size() == 1) check("post_rst_word", mq[0], {2'b11, 4'hF, 32'hDDCCBBAA});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
